// File: rtl/vga_pixel_stream.sv
// vga_pixel_stream: packs active VGA pixels into 24-bit words, buffers them
// in a first-word-fall-through FIFO and streams them out with sof/eol tags.
//
// Ports:
//   clk, sim_rst_n                  pixel clock, async active-low reset
//   counter_x, counter_y            registered coordinates from the paint stage
//   sdl_de                          incoming pixel is active
//   red_i, green_i, blue_i          8-bit colour channels
//   m_valid, m_ready                output stream handshake
//   m_data                          {red, green, blue} of the head word
//   m_sof, m_eol                    head word is pixel (0,0) / last of a line
//   overflow                        sticky: a pixel was dropped on a full FIFO
//   frame_cnt                       frames whose first pixel entered the FIFO
//   fifo_level                      current FIFO occupancy

module vga_pixel_stream #(
    parameter int CORDW = 10,
    parameter int H_RES = 640,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     sim_rst_n,
    input  logic [CORDW-1:0]         counter_x,
    input  logic [CORDW-1:0]         counter_y,
    input  logic                     sdl_de,
    input  logic [7:0]               red_i,
    input  logic [7:0]               green_i,
    input  logic [7:0]               blue_i,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [23:0]              m_data,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic                     overflow,
    output logic [15:0]              frame_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 26;

    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [CORDW-1:0] LAST_X   = CORDW'(H_RES - 1);

    typedef enum logic [1:0] {
        WAIT_SOF,
        STREAM,
        RESYNC
    } state_t;

    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [EW-1:0]   head;
    logic [EW-1:0]   entry;
    logic            px_sof;
    logic            px_eol;
    logic            pop;
    logic            space;
    logic            push;

    // Tag the incoming pixel with its frame/line position.
    assign px_sof = (counter_x == '0) && (counter_y == '0);
    assign px_eol = (counter_x == LAST_X);
    assign entry  = {px_sof, px_eol, red_i, green_i, blue_i};

    // A pop in the same cycle frees a slot, so a full FIFO can still
    // accept a word while the head is being taken.
    assign pop   = (level != '0) && m_ready;
    assign space = (level < FULL_LVL) || pop;

    // Only STREAM pushes arbitrary pixels; the other states wait for a
    // frame start so the sink never sees a partial frame.
    always_comb begin
        push = 1'b0;
        if (sdl_de && space) begin
            case (state)
                WAIT_SOF: push = px_sof;
                RESYNC:   push = px_sof;
                STREAM:   push = 1'b1;
                default:  push = 1'b0;
            endcase
        end
    end

    // Storage is not reset: occupancy is tracked by level and the
    // outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Frame-alignment state machine with its sticky status outputs.
    always_ff @(posedge clk or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            state     <= WAIT_SOF;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (push && px_sof) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (sdl_de) begin
                case (state)
                    WAIT_SOF: begin
                        if (push) begin
                            state <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (!space) begin
                            overflow <= 1'b1;
                            state    <= RESYNC;
                        end
                    end
                    RESYNC: begin
                        if (push) begin
                            state <= STREAM;
                        end
                    end
                    default: state <= WAIT_SOF;
                endcase
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign m_valid    = (level != '0);
    assign m_data     = m_valid ? head[23:0] : 24'h0;
    assign m_sof      = m_valid & head[25];
    assign m_eol      = m_valid & head[24];
    assign fifo_level = level;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// tb_vga_pixel_stream: scoreboard bench for vga_pixel_stream.
// Stimulus queues expected words; a negedge monitor pops and compares.

module tb_vga_pixel_stream;

    localparam int CORDW = 10;
    localparam int H_RES = 16;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             sim_rst_n;
    logic [CORDW-1:0] counter_x;
    logic [CORDW-1:0] counter_y;
    logic             sdl_de;
    logic [7:0]       red_i;
    logic [7:0]       green_i;
    logic [7:0]       blue_i;
    logic             m_valid;
    logic             m_ready;
    logic [23:0]      m_data;
    logic             m_sof;
    logic             m_eol;
    logic             overflow;
    logic [15:0]      frame_cnt;
    logic [LW-1:0]    fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [25:0] exp_q [$];

    always #5 clk = ~clk;

    vga_pixel_stream #(
        .CORDW(CORDW),
        .H_RES(H_RES),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .sim_rst_n(sim_rst_n),
        .counter_x(counter_x),
        .counter_y(counter_y),
        .sdl_de(sdl_de),
        .red_i(red_i),
        .green_i(green_i),
        .blue_i(blue_i),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_sof(m_sof),
        .m_eol(m_eol),
        .overflow(overflow),
        .frame_cnt(frame_cnt),
        .fifo_level(fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Present one pixel, queue its expected word if it should be kept,
    // then advance past the sampling edge.
    task automatic px(input int x, input int y, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b,
                      input logic keep);
        counter_x = CORDW'(x);
        counter_y = CORDW'(y);
        sdl_de    = 1'b1;
        red_i     = r;
        green_i   = g;
        blue_i    = b;
        if (keep) begin
            exp_q.push_back({(x == 0 && y == 0), (x == H_RES - 1), r, g, b});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sdl_de = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: words are consumed on the edge following a negedge that
    // sees m_valid && m_ready; stalled words must not change.
    logic        hold_v = 1'b0;
    logic [25:0] hold_w = '0;

    always @(negedge clk) begin
        if (!sim_rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && m_valid) begin
                check("stall_stable", 32'({m_sof, m_eol, m_data}), 32'(hold_w));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h required none",
                             {m_sof, m_eol, m_data});
                end else begin
                    check("word", 32'({m_sof, m_eol, m_data}),
                          32'(exp_q.pop_front()));
                end
            end
            hold_v = m_valid && !m_ready;
            hold_w = {m_sof, m_eol, m_data};
        end
    end

    initial begin
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         maxl;
        int         k;

        sim_rst_n = 1'b1;
        sdl_de    = 1'b0;
        counter_x = '0;
        counter_y = '0;
        red_i     = '0;
        green_i   = '0;
        blue_i    = '0;
        m_ready   = 1'b0;

        // Reset state
        #2 sim_rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_frames", 32'(frame_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'({m_sof, m_eol, m_data}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 sim_rst_n = 1'b1;

        // Pixels before the first frame start are discarded
        m_ready = 1'b1;
        px(5, 0, 8'h01, 8'h02, 8'h03, 1'b0);
        px(6, 0, 8'h04, 8'h05, 8'h06, 1'b0);
        check("presof_level", 32'(fifo_level), 32'd0);
        px(0, 0, 8'h11, 8'h33, 8'h77, 1'b1);
        check("sof_valid", 32'(m_valid), 32'd1);
        check("sof_data", 32'(m_data), 32'h113377);
        check("sof_flag", 32'(m_sof), 32'd1);
        check("sof_frames", 32'(frame_cnt), 32'd1);
        idle(2);

        // Whole small frame with m_ready held high
        maxl = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < H_RES; x++) begin
                px(x, y, 8'(x * 8), 8'(y * 16), 8'(x ^ y), 1'b1);
                if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
            end
            idle(4);
        end
        check("frame_maxlvl_le1", 32'(maxl <= 1), 32'd1);
        check("frame_ovf", 32'(overflow), 32'd0);
        check("frame_frames", 32'(frame_cnt), 32'd2);

        // Overflow with m_ready low: 16 kept, 17th drops and resyncs
        m_ready = 1'b0;
        for (k = 0; k < 20; k++) begin
            px(k % H_RES, 1 + k / H_RES, 8'(k), 8'hc0, 8'(255 - k), k < 16);
            if (k == 15) begin
                check("ovf_level16", 32'(fifo_level), 32'd16);
                check("ovf_not_yet", 32'(overflow), 32'd0);
            end
            if (k == 16) check("ovf_set", 32'(overflow), 32'd1);
        end
        check("ovf_level_sat", 32'(fifo_level), 32'd16);
        m_ready = 1'b1;
        idle(20);
        check("ovf_drained", 32'(fifo_level), 32'd0);
        check("ovf_drain_cnt", 32'(exp_q.size()), 32'd0);
        for (int x = 4; x < H_RES; x++) px(x, 2, 8'h55, 8'h55, 8'h55, 1'b0);
        check("resync_discard", 32'(fifo_level), 32'd0);
        px(0, 0, 8'haa, 8'hbb, 8'hcc, 1'b1);
        check("resync_sof", 32'(m_sof), 32'd1);
        check("resync_data", 32'(m_data), 32'haabbcc);
        check("resync_frames", 32'(frame_cnt), 32'd3);
        check("ovf_sticky", 32'(overflow), 32'd1);
        px(1, 0, 8'h10, 8'h20, 8'h30, 1'b1);
        px(2, 0, 8'h40, 8'h50, 8'h60, 1'b1);
        idle(3);

        // Asynchronous reset mid-line with nine words buffered
        m_ready = 1'b0;
        for (int x = 3; x < 12; x++) px(x, 0, 8'(x), 8'h0f, 8'hf0, 1'b1);
        check("mid_level9", 32'(fifo_level), 32'd9);
        #2 sim_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_valid", 32'(m_valid), 32'd0);
        check("async_level", 32'(fifo_level), 32'd0);
        check("async_frames", 32'(frame_cnt), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 sim_rst_n = 1'b1;
        m_ready = 1'b1;
        px(12, 0, 8'h01, 8'h01, 8'h01, 1'b0);
        px(13, 0, 8'h02, 8'h02, 8'h02, 1'b0);
        px(5, 1, 8'h03, 8'h03, 8'h03, 1'b0);
        check("post_rst_discard", 32'(fifo_level), 32'd0);

        // Full FIFO with simultaneous push and pop
        m_ready = 1'b0;
        for (int x = 0; x < H_RES; x++) px(x, 0, 8'(x + 100), 8'h77, 8'(x), 1'b1);
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_frames", 32'(frame_cnt), 32'd1);
        m_ready = 1'b1;
        px(0, 1, 8'hde, 8'had, 8'hbe, 1'b1);
        check("pushpop_level", 32'(fifo_level), 32'd16);
        check("pushpop_ovf", 32'(overflow), 32'd0);
        idle(20);
        check("pushpop_drained", 32'(fifo_level), 32'd0);
        check("pushpop_q_empty", 32'(exp_q.size()), 32'd0);

        // Three frames of random colours with m_ready toggling each cycle
        for (int f = 0; f < 3; f++) begin
            for (int y = 0; y < 3; y++) begin
                for (int x = 0; x < H_RES; x++) begin
                    r = 8'($urandom);
                    g = 8'($urandom);
                    b = 8'($urandom);
                    m_ready = ~m_ready;
                    px(x, y, r, g, b, 1'b1);
                    m_ready = ~m_ready;
                    idle(1);
                    m_ready = ~m_ready;
                    idle(1);
                end
            end
        end
        m_ready = 1'b1;
        idle(10);
        check("toggle_frames", 32'(frame_cnt), 32'd4);
        check("toggle_ovf", 32'(overflow), 32'd0);

        // Bounded wait for the scoreboard to empty
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_level", 32'(fifo_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
